// File: rtl/tri_loc_ingest_if.sv
`default_nettype none
// ============================================================================
//  Module      : tri_loc_ingest_if
//  Description : Bundles the anchor-config strobe, the range-sample stream and
//                the assembled trilateration frame. The master drives
//                configuration, samples and m_ready. The slave (the ingest
//                block) drives s_ready and the frame outputs.
//  Revision    : 1.0  initial release
// ============================================================================
interface tri_loc_ingest_if #(
    parameter int N = 8
);
    // Anchor coordinate configuration
    logic                cfg_we;
    logic [1:0]          cfg_id;
    logic signed [N-1:0] cfg_x;
    logic signed [N-1:0] cfg_y;

    // Range sample stream
    logic                s_valid;
    logic                s_ready;
    logic [1:0]          s_id;
    logic signed [N:0]   s_range;

    // Assembled frame
    logic                m_valid;
    logic                m_ready;
    logic signed [N-1:0] xA, yA, xB, yB, xC, yC;
    logic signed [N:0]   rA, rB, rC;

    // Status
    logic                err;
    logic [7:0]          drop_cnt;

    modport master (
        output cfg_we, cfg_id, cfg_x, cfg_y,
        output s_valid, s_id, s_range, m_ready,
        input  s_ready, m_valid,
        input  xA, yA, xB, yB, xC, yC, rA, rB, rC,
        input  err, drop_cnt
    );

    modport slave (
        input  cfg_we, cfg_id, cfg_x, cfg_y,
        input  s_valid, s_id, s_range, m_ready,
        output s_ready, m_valid,
        output xA, yA, xB, yB, xC, yC, rA, rB, rC,
        output err, drop_cnt
    );
endinterface
`default_nettype wire

// File: rtl/tri_loc_ingest.sv
`default_nettype none
// ============================================================================
//  Module      : tri_loc_ingest
//  Description : Collects one range sample per anchor (A, B, C) into a frame.
//                The block presents each complete frame with the current
//                anchor coordinates on a valid/ready output slot. A sample
//                tagged id 3 or carrying a negative range is rejected and
//                raises the sticky err flag.
//                Optional macro TRILOC_TIMEOUT_EN adds an idle timer. The
//                timer discards a partial frame after TIMEOUT cycles without
//                a sample and counts each discard in drop_cnt (saturating).
//  Revision    : 1.0  initial release
// ============================================================================
module tri_loc_ingest #(
    parameter int N       = 8,
    parameter int TIMEOUT = 255
) (
    input  wire logic       clk,
    input  wire logic       rst,
    tri_loc_ingest_if.slave bus
);

    // Anchor coordinates, collected ranges and output frame (index 0=A,1=B,2=C)
    logic signed [N-1:0] r_ax  [3];
    logic signed [N-1:0] r_ay  [3];
    logic signed [N:0]   r_col [3];
    logic signed [N-1:0] r_ox  [3];
    logic signed [N-1:0] r_oy  [3];
    logic signed [N:0]   r_or  [3];

    logic [2:0] r_mask;
    logic       r_mvalid;
    logic       r_err;

    logic w_full;
    logic w_ready;
    logic w_acc;
    logic w_good;
    logic w_load;
    logic w_drop;

    // The collector state is encoded by the mask itself: 0 means EMPTY,
    // 7 means FULL, and any other value means PARTIAL.
    assign w_full  = &r_mask;
    assign w_ready = ~w_full;
    assign w_acc   = bus.s_valid & w_ready;
    assign w_good  = (bus.s_id != 2'd3) && !bus.s_range[N];
    // A full frame moves out when the output slot is empty or is being drained.
    assign w_load  = w_full && (!r_mvalid || bus.m_ready);

`ifdef TRILOC_TIMEOUT_EN
    localparam int c_idle_w = $clog2(TIMEOUT + 1);

    logic [c_idle_w-1:0] r_idle;
    logic [7:0]          r_drop;
    logic                w_partial;

    assign w_partial = (r_mask != 3'b000) && !w_full;
    assign w_drop    = w_partial && !w_acc && (r_idle == c_idle_w'(TIMEOUT - 1));

    // Idle timer for partial frames, and a saturating count of discarded frames
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idle <= '0;
            r_drop <= 8'd0;
        end else if (!w_partial || w_acc || w_drop) begin
            r_idle <= '0;
            if (w_drop && r_drop != 8'hFF) begin
                r_drop <= r_drop + 8'd1;
            end
        end else begin
            r_idle <= r_idle + 1'b1;
        end
    end

    assign bus.drop_cnt = r_drop;
`else
    assign w_drop       = 1'b0;
    assign bus.drop_cnt = 8'd0;
`endif

    // Anchor coordinate registers. Writes to id 3 are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                r_ax[i] <= '0;
                r_ay[i] <= '0;
            end
        end else if (bus.cfg_we) begin
            for (int i = 0; i < 3; i++) begin
                if (bus.cfg_id == 2'(i)) begin
                    r_ax[i] <= bus.cfg_x;
                    r_ay[i] <= bus.cfg_y;
                end
            end
        end
    end

    // Range collection. The latest sample for an id overwrites any earlier one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                r_col[i] <= '0;
            end
        end else if (w_acc && w_good) begin
            for (int i = 0; i < 3; i++) begin
                if (bus.s_id == 2'(i)) begin
                    r_col[i] <= bus.s_range;
                end
            end
        end
    end

    // Collection mask. It is cleared when the frame moves out or times out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mask <= 3'b000;
        end else if (w_load || w_drop) begin
            r_mask <= 3'b000;
        end else if (w_acc && w_good) begin
            r_mask <= r_mask | (3'b001 << bus.s_id);
        end
    end

    // Sticky error flag for rejected samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_acc && !w_good) begin
            r_err <= 1'b1;
        end
    end

    // Output slot. Loading captures the pre-edge coordinates, so a cfg write
    // in the same cycle does not reach this frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mvalid <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                r_ox[i] <= '0;
                r_oy[i] <= '0;
                r_or[i] <= '0;
            end
        end else if (w_load) begin
            r_mvalid <= 1'b1;
            for (int i = 0; i < 3; i++) begin
                r_ox[i] <= r_ax[i];
                r_oy[i] <= r_ay[i];
                r_or[i] <= r_col[i];
            end
        end else if (bus.m_ready) begin
            r_mvalid <= 1'b0;
        end
    end

    assign bus.s_ready = w_ready;
    assign bus.m_valid = r_mvalid;
    assign bus.err     = r_err;
    assign bus.xA      = r_ox[0];
    assign bus.yA      = r_oy[0];
    assign bus.xB      = r_ox[1];
    assign bus.yB      = r_oy[1];
    assign bus.xC      = r_ox[2];
    assign bus.yC      = r_oy[2];
    assign bus.rA      = r_or[0];
    assign bus.rB      = r_or[1];
    assign bus.rC      = r_or[2];

endmodule
`default_nettype wire

// File: doc/tri_loc_ingest.md
TRI_LOC_INGEST -- requirements
Module: tri_loc_ingest

Interface
REQ-001 The block SHALL have parameter N, default 8, giving the anchor coordinate width; range width is N+1.
REQ-002 The block SHALL have parameter TIMEOUT, default 255, giving the idle cycles before a partial frame is discarded.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 Port cfg_we, input, 1 bit: anchor coordinate write strobe.
REQ-006 Port cfg_id, input, 2 bits: anchor select for the write (0=A, 1=B, 2=C, 3=ignored).
REQ-007 Port cfg_x and port cfg_y, input, signed N bits each: anchor coordinates to write.
REQ-008 Port s_valid, input, 1 bit: range sample valid.
REQ-009 Port s_ready, output, 1 bit: range sample ready.
REQ-010 Port s_id, input, 2 bits: anchor tag of the range sample.
REQ-011 Port s_range, input, signed N+1 bits: measured range.
REQ-012 Port m_valid, output, 1 bit: frame valid.
REQ-013 Port m_ready, input, 1 bit: downstream trilateration stage accepts the frame.
REQ-014 Ports xA, yA, xB, yB, xC, yC, output, signed N bits each: the frame's anchor coordinates.
REQ-015 Ports rA, rB, rC, output, signed N+1 bits each: the frame's ranges.
REQ-016 Port err, output, 1 bit: sticky flag for rejected samples.
REQ-017 Port drop_cnt, output, 8 bits: saturating count of discarded partial frames.

Function
REQ-018 Anchor coordinate registers SHALL load on cfg_we for cfg_id 0 to 2; cfg_id 3 SHALL be ignored.
REQ-019 A sample SHALL be accepted in a cycle when s_valid and s_ready are both 1.
REQ-020 An accepted sample SHALL write the collect register for s_id and set bit s_id of a 3-bit mask.
REQ-021 A repeated id in the same frame SHALL overwrite the earlier range, keeping the latest value.
REQ-022 An accepted sample with s_id==3 or a negative s_range SHALL be dropped and SHALL set err; the mask SHALL NOT change.
REQ-023 Collector states: EMPTY (mask 0), PARTIAL (mask nonzero, not 7), FULL (mask 7).
REQ-024 s_ready SHALL equal 1 in EMPTY and PARTIAL and 0 in FULL.
REQ-025 In FULL, when m_valid==0 or m_ready==1, the block SHALL load the collected ranges plus the current anchor coordinates into the output registers, set m_valid, and clear the mask.
REQ-026 Latency: for a third distinct id accepted at edge k with the output slot free, m_valid SHALL be 1 after edge k+1.
REQ-027 m_valid SHALL remain 1, with outputs stable, until a cycle in which m_ready==1.
REQ-028 On a transfer with no new frame loading, m_valid SHALL clear at that edge.
REQ-029 A transfer and a load in the same cycle SHALL keep m_valid at 1 with the new frame (back-to-back, no bubble).
REQ-030 A cfg write after the output load SHALL NOT alter the presented frame.
REQ-031 A cfg write in the same cycle as the output load SHALL present the old coordinates.
REQ-032 drop_cnt SHALL saturate at 255.

Reset
REQ-033 rst SHALL force mask=0 (so s_ready=1), m_valid=0, all coordinate, range and output data registers=0, err=0, drop_cnt=0, and the timeout counter=0.
REQ-034 rst asserted mid-frame or mid-handshake SHALL discard the frame without incrementing drop_cnt.

Configuration
REQ-035 Macro TRILOC_TIMEOUT_EN defined: in PARTIAL, an idle counter SHALL count cycles with no accepted sample.
REQ-036 With TRILOC_TIMEOUT_EN defined, the idle counter SHALL reset on each accepted sample; on reaching TIMEOUT it SHALL clear the mask, increment drop_cnt and return to EMPTY.
REQ-037 Macro TRILOC_TIMEOUT_EN undefined: no counter SHALL exist, partial frames SHALL wait indefinitely, and drop_cnt SHALL stay 0.

Verification
REQ-038 Write anchors A(0,0), B(20,0), C(0,20); send ids 0,1,2 with ranges 10,15,15 and m_ready=1 -> m_valid pulses one cycle, 2 cycles after the third sample, carrying those values.
REQ-039 Hold m_ready=0 and send two full frames -> the first frame is held stable, s_ready drops after the sixth sample, and the second frame appears the cycle after m_ready rises, with no bubble.
REQ-040 Send id 1 range 30, then id 1 range 12, then ids 0 and 2 -> rB=12.
REQ-041 Send s_id=3 and then range -5 -> err=1, no frame produced, mask unchanged.
REQ-042 With TRILOC_TIMEOUT_EN and TIMEOUT=4, send id 0 then idle 4 cycles -> drop_cnt=1 and the next 3 samples form a clean frame.
REQ-043 Assert rst after 2 samples -> m_valid=0, s_ready=1, drop_cnt=0, and the next full frame contains only post-reset samples.
